// File: rtl/dram_path_responder_pkg.sv
// DDR3 local-interface constants shared by the
// DRAM responder and its queues.
package dram_path_responder_pkg;

  localparam int DDR_AWIDTH = 28;
  localparam int DDR_CWIDTH = 3;
  localparam int DDR_DWIDTH = 512;
  localparam int DDR_MWIDTH = 64;

  localparam logic [2:0] DDR3CMD_Write = 3'd0;
  localparam logic [2:0] DDR3CMD_Read  = 3'd1;

endpackage

// File: rtl/dram_resp_fifo.sv
// Small synchronous FIFO with registered full and
// empty flags; a push is refused while full.
module dram_resp_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_push,
  input  logic [W-1:0] i_din,
  input  logic         i_pop,
  output logic [W-1:0] o_dout,
  output logic         o_full,
  output logic         o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wp;
  logic [AW-1:0] r_rp;
  logic [AW:0]   r_cnt;
  logic          r_full;
  logic          r_empty;
  logic          w_push;
  logic          w_pop;
  logic [AW:0]   w_cnt_nx;

  assign w_push   = i_push & ~r_full;
  assign w_pop    = i_pop & ~r_empty;
  assign w_cnt_nx = r_cnt + (AW+1)'(w_push)
                  - (AW+1)'(w_pop);

  // pointer, occupancy and flag registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_cnt   <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
    end else begin
      if (w_push) r_wp <= r_wp + AW'(1);
      if (w_pop)  r_rp <= r_rp + AW'(1);
      r_cnt   <= w_cnt_nx;
      r_full  <= (w_cnt_nx == (AW+1)'(DEPTH));
      r_empty <= (w_cnt_nx == '0);
    end
  end

  // storage array, no reset needed
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wp] <= i_din;
  end

  assign o_dout  = r_mem[r_rp];
  assign o_full  = r_full;
  assign o_empty = r_empty;

endmodule

// File: rtl/dram_path_responder.sv
// On-chip stand-in for the DDR3 controller: queued
// writes, fixed-latency reads, optional cmd stalls.
module dram_path_responder
  import dram_path_responder_pkg::*;
#(
  parameter int DDRAWidth   = DDR_AWIDTH,
  parameter int DDRCWidth   = DDR_CWIDTH,
  parameter int DDRDWidth   = DDR_DWIDTH,
  parameter int DDRMWidth   = DDR_MWIDTH,
  parameter int MemAW       = 10,
  parameter int ReadLatency = 4,
  parameter int QDepth      = 8,
  parameter int StallPeriod = 0
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic [DDRAWidth-1:0] DRAMAddress,
  input  logic [DDRCWidth-1:0] DRAMCommand,
  input  logic                 DRAMCommandValid,
  output logic                 DRAMCommandReady,
  output logic [DDRDWidth-1:0] DRAMReadData,
  output logic                 DRAMReadDataValid,
  input  logic [DDRDWidth-1:0] DRAMWriteData,
  input  logic [DDRMWidth-1:0] DRAMWriteMask,
  input  logic                 DRAMWriteDataValid,
  output logic                 DRAMWriteDataReady,
  output logic                 Error
);

  localparam int Depth = 1 << MemAW;
  localparam int AQW   = MemAW + 1;
  localparam int DQW   = DDRDWidth + DDRMWidth;

  logic                 r_live;
  logic                 r_err;
  logic                 w_stall;
  logic                 w_is_wr;
  logic                 w_is_rd;
  logic                 w_oor;
  logic [MemAW-1:0]     w_idx;
  logic                 w_cmd_acc;
  logic                 w_wr_acc;
  logic                 w_rd_acc;
  logic                 w_wd_acc;
  logic                 w_commit;
  logic                 w_aq_full;
  logic                 w_aq_empty;
  logic                 w_dq_full;
  logic                 w_dq_empty;
  logic [AQW-1:0]       w_aq_dout;
  logic [DQW-1:0]       w_dq_dout;
  logic [DDRDWidth-1:0] w_wdata;
  logic [DDRMWidth-1:0] w_wmask;

  assign w_idx   = DRAMAddress[MemAW+2:3];
  assign w_oor   = |(DRAMAddress >> (MemAW + 3));
  assign w_is_wr = DRAMCommand ==
                   DDRCWidth'(DDR3CMD_Write);
  assign w_is_rd = DRAMCommand ==
                   DDRCWidth'(DDR3CMD_Read);

  assign w_commit = ~w_aq_empty & ~w_dq_empty;

  // reads wait until every queued write has landed
  assign DRAMCommandReady = r_live & ~w_aq_full
    & ~w_stall
    & (w_is_wr | (w_aq_empty & ~w_commit));
  assign DRAMWriteDataReady = r_live & ~w_dq_full;

  assign w_cmd_acc = DRAMCommandValid
                   & DRAMCommandReady;
  assign w_wr_acc  = w_cmd_acc & w_is_wr;
  assign w_rd_acc  = w_cmd_acc & w_is_rd;
  assign w_wd_acc  = DRAMWriteDataValid
                   & DRAMWriteDataReady;

  dram_resp_fifo #(
    .W     (AQW),
    .DEPTH (QDepth)
  ) u_aq (
    .i_clk   (Clock),
    .i_rst_n (Reset),
    .i_push  (w_wr_acc),
    .i_din   ({w_oor, w_idx}),
    .i_pop   (w_commit),
    .o_dout  (w_aq_dout),
    .o_full  (w_aq_full),
    .o_empty (w_aq_empty)
  );

  dram_resp_fifo #(
    .W     (DQW),
    .DEPTH (QDepth)
  ) u_dq (
    .i_clk   (Clock),
    .i_rst_n (Reset),
    .i_push  (w_wd_acc),
    .i_din   ({DRAMWriteMask, DRAMWriteData}),
    .i_pop   (w_commit),
    .o_dout  (w_dq_dout),
    .o_full  (w_dq_full),
    .o_empty (w_dq_empty)
  );

  assign {w_wmask, w_wdata} = w_dq_dout;

  if (StallPeriod > 0) begin : g_stall
    localparam int SW = $clog2(StallPeriod + 1);
    logic [SW-1:0] r_cnt;
    // free-running slot counter for forced stalls
    always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset)
        r_cnt <= '0;
      else if (r_cnt == SW'(StallPeriod - 1))
        r_cnt <= '0;
      else
        r_cnt <= r_cnt + SW'(1);
    end
    assign w_stall = (r_cnt == SW'(StallPeriod - 1));
  end else begin : g_nostall
    assign w_stall = 1'b0;
  end

  // ready enable after reset and sticky error flag
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_live <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_live <= 1'b1;
      if (w_cmd_acc & ((~w_is_wr & ~w_is_rd) | w_oor))
        r_err <= 1'b1;
    end
  end

  logic [DDRDWidth-1:0] r_mem [Depth];
  logic [DDRDWidth-1:0] r_ram_q;

  // byte-masked commit and read at acceptance
  always_ff @(posedge Clock) begin
    if (w_commit && !w_aq_dout[MemAW]) begin
      for (int b = 0; b < DDRMWidth; b++) begin
        if (!w_wmask[b])
          r_mem[w_aq_dout[MemAW-1:0]][b*8 +: 8]
            <= w_wdata[b*8 +: 8];
      end
    end
    if (w_rd_acc) r_ram_q <= r_mem[w_idx];
  end

  logic [ReadLatency-1:0] r_vpipe;
  logic [DDRDWidth-1:0]   r_dpipe [1:ReadLatency-1];

  // read return pipeline, flushed by reset
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_vpipe <= '0;
      for (int i = 1; i < ReadLatency; i++)
        r_dpipe[i] <= '0;
    end else begin
      r_vpipe <= {r_vpipe[ReadLatency-2:0], w_rd_acc};
      r_dpipe[1] <= r_ram_q;
      for (int i = 2; i < ReadLatency; i++)
        r_dpipe[i] <= r_dpipe[i-1];
    end
  end

  assign DRAMReadDataValid = r_vpipe[ReadLatency-1];
  assign DRAMReadData      = r_dpipe[ReadLatency-1];
  assign Error             = r_err;

endmodule

// File: tb/tb_dram_path_responder.sv
// Scoreboard bench for dram_path_responder: reads are
// predicted from a bench memory model and latency.
module tb_dram_path_responder;

  localparam int RL = 4;
  localparam logic [2:0] WR = 3'd0;
  localparam logic [2:0] RD = 3'd1;

  typedef struct {
    logic [511:0] d;
    int           c;
  } rd_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic [27:0]  addr = '0;
  logic [2:0]   cmd = '0;
  logic         cvalid = 1'b0;
  logic         cready;
  logic [511:0] rdata;
  logic         rvalid;
  logic [511:0] wdata = '0;
  logic [63:0]  wmask = '0;
  logic         dvalid = 1'b0;
  logic         dready;
  logic         err;

  logic [27:0]  s_addr = '0;
  logic [2:0]   s_cmd = '0;
  logic         s_cvalid = 1'b0;
  logic         s_cready;
  logic [511:0] s_rdata;
  logic         s_rvalid;
  logic [511:0] s_wdata = '0;
  logic [63:0]  s_wmask = '0;
  logic         s_dvalid = 1'b0;
  logic         s_dready;
  logic         s_err;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  rd_t exp_q[$];
  rd_t obs_q[$];
  logic [511:0] model [int];

  dram_path_responder u_dut (
    .Clock              (clk),
    .Reset              (rst_n),
    .DRAMAddress        (addr),
    .DRAMCommand        (cmd),
    .DRAMCommandValid   (cvalid),
    .DRAMCommandReady   (cready),
    .DRAMReadData       (rdata),
    .DRAMReadDataValid  (rvalid),
    .DRAMWriteData      (wdata),
    .DRAMWriteMask      (wmask),
    .DRAMWriteDataValid (dvalid),
    .DRAMWriteDataReady (dready),
    .Error              (err)
  );

  dram_path_responder #(.StallPeriod(4)) u_stall (
    .Clock              (clk),
    .Reset              (rst_n),
    .DRAMAddress        (s_addr),
    .DRAMCommand        (s_cmd),
    .DRAMCommandValid   (s_cvalid),
    .DRAMCommandReady   (s_cready),
    .DRAMReadData       (s_rdata),
    .DRAMReadDataValid  (s_rvalid),
    .DRAMWriteData      (s_wdata),
    .DRAMWriteMask      (s_wmask),
    .DRAMWriteDataValid (s_dvalid),
    .DRAMWriteDataReady (s_dready),
    .Error              (s_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rvalid === 1'b1) obs_q.push_back('{rdata, cyc});
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic model_write(input int idx,
                             input logic [511:0] d,
                             input logic [63:0] m);
    logic [511:0] v;
    v = model.exists(idx) ? model[idx] : '0;
    for (int b = 0; b < 64; b++)
      if (!m[b]) v[b*8 +: 8] = d[b*8 +: 8];
    model[idx] = v;
  endtask

  function automatic logic [511:0] rnd512();
    logic [511:0] v;
    for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom();
    return v;
  endfunction

  task automatic send_cmd(input logic [2:0] c,
                          input logic [27:0] a,
                          input bit track);
    bit done;
    done = 0;
    cmd = c; addr = a; cvalid = 1'b1;
    for (int k = 0; k < 100 && !done; k++) begin
      @(negedge clk);
      if (cready === 1'b1) begin
        done = 1;
        if (track && c == RD)
          exp_q.push_back('{model[int'(a[12:3])], cyc + RL});
      end
      @(posedge clk); #1;
    end
    cvalid = 1'b0;
    if (!done) begin
      checks++; errors++;
      $display("FAIL cmd_timeout cmd=%0d addr=%h never accepted", c, a);
    end
  endtask

  task automatic send_data(input logic [511:0] d,
                           input logic [63:0] m);
    bit done;
    done = 0;
    wdata = d; wmask = m; dvalid = 1'b1;
    for (int k = 0; k < 100 && !done; k++) begin
      @(negedge clk);
      if (dready === 1'b1) done = 1;
      @(posedge clk); #1;
    end
    dvalid = 1'b0;
    if (!done) begin
      checks++; errors++;
      $display("FAIL data_timeout beat never accepted");
    end
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (cready !== 1'b0) begin errors++; $display("FAIL rst_cready got=%b exp=0", cready); end
    checks++;
    if (dready !== 1'b0) begin errors++; $display("FAIL rst_dready got=%b exp=0", dready); end
    checks++;
    if (rvalid !== 1'b0) begin errors++; $display("FAIL rst_rvalid got=%b exp=0", rvalid); end
    checks++;
    if (rdata !== '0) begin errors++; $display("FAIL rst_rdata got=%h exp=0", rdata); end
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL rst_error got=%b exp=0", err); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (cready !== 1'b1) begin errors++; $display("FAIL post_rst_cready got=%b exp=1", cready); end
    checks++;
    if (dready !== 1'b1) begin errors++; $display("FAIL post_rst_dready got=%b exp=1", dready); end
  endtask

  task automatic test_write_read();
    logic [511:0] d;
    rd_t e, o;
    d = {64{8'hA5}};
    send_cmd(WR, 28'h40, 0);
    send_data(d, '0);
    model_write(8, d, '0);
    idle(2);
    send_cmd(RD, 28'h40, 1);
    idle(RL + 4);
    checks++;
    if (obs_q.size() !== 1) begin errors++; $display("FAIL wr_rd_count got=%0d exp=1", obs_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if (o.d !== d) begin errors++; $display("FAIL wr_rd_data got=%h exp=%h", o.d, d); end
      checks++;
      if (o.c !== e.c) begin errors++; $display("FAIL wr_rd_latency got=%0d exp=%0d", o.c, e.c); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_data_first();
    logic [511:0] d [3];
    rd_t e, o;
    for (int i = 0; i < 3; i++) begin
      d[i] = rnd512();
      send_data(d[i], '0);
    end
    for (int i = 0; i < 3; i++) begin
      send_cmd(WR, 28'(i * 8), 0);
      model_write(i, d[i], '0);
    end
    for (int i = 0; i < 3; i++) send_cmd(RD, 28'(i * 8), 1);
    idle(RL + 4);
    checks++;
    if (obs_q.size() !== 3) begin errors++; $display("FAIL df_count got=%0d exp=3", obs_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if (o.d !== e.d) begin errors++; $display("FAIL df_data got=%h exp=%h", o.d, e.d); end
      checks++;
      if (o.c !== e.c) begin errors++; $display("FAIL df_latency got=%0d exp=%0d", o.c, e.c); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_mask();
    logic [511:0] want;
    rd_t o;
    want = {512{1'b1}};
    want[7:0] = 8'h00;
    send_cmd(WR, 28'h8, 0);
    send_data({512{1'b1}}, '0);
    model_write(1, {512{1'b1}}, '0);
    send_cmd(WR, 28'h8, 0);
    send_data('0, 64'hFFFF_FFFF_FFFF_FFFE);
    model_write(1, '0, 64'hFFFF_FFFF_FFFF_FFFE);
    send_cmd(RD, 28'h8, 1);
    idle(RL + 4);
    checks++;
    if (obs_q.size() !== 1) begin errors++; $display("FAIL mask_count got=%0d exp=1", obs_q.size()); end
    if (obs_q.size() > 0) begin
      o = obs_q.pop_front();
      checks++;
      if (o.d !== want) begin errors++; $display("FAIL mask_data got=%h exp=%h", o.d, want); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_raw_stall();
    logic [511:0] d0, d1;
    rd_t e, o;
    int acc_k;
    d0 = rnd512(); d1 = rnd512();
    send_cmd(WR, 28'h100, 0);
    send_cmd(WR, 28'h108, 0);
    model_write(32, d0, '0);
    model_write(33, d1, '0);
    acc_k = -1;
    wdata = d0; wmask = '0; dvalid = 1'b1;
    cmd = RD; addr = 28'h100; cvalid = 1'b1;
    for (int k = 0; k < 8 && acc_k < 0; k++) begin
      @(negedge clk);
      if (cready === 1'b1) begin
        acc_k = k;
        exp_q.push_back('{model[32], cyc + RL});
      end
      @(posedge clk); #1;
      if (k == 0) wdata = d1;
      if (k == 1) dvalid = 1'b0;
    end
    cvalid = 1'b0; dvalid = 1'b0;
    checks++;
    if (acc_k !== 3) begin errors++; $display("FAIL raw_accept_cycle got=%0d exp=3", acc_k); end
    idle(RL + 4);
    checks++;
    if (obs_q.size() !== exp_q.size()) begin errors++; $display("FAIL raw_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if (o.d !== e.d) begin errors++; $display("FAIL raw_data got=%h exp=%h", o.d, e.d); end
      checks++;
      if (o.c !== e.c) begin errors++; $display("FAIL raw_latency got=%0d exp=%0d", o.c, e.c); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_backpressure();
    logic [511:0] d [16];
    logic [15:0] s;
    int lows;
    bit per_ok;
    for (int i = 0; i < 16; i++) d[i] = rnd512();
    for (int i = 0; i < 8; i++) send_data(d[i], '0);
    @(negedge clk);
    checks++;
    if (dready !== 1'b0) begin errors++; $display("FAIL dq_full_ready got=%b exp=0", dready); end
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) begin
      send_cmd(WR, 28'h200 + 28'(i * 8), 0);
      model_write(64 + i, d[i], '0);
    end
    for (int i = 8; i < 16; i++)
      send_cmd(WR, 28'h200 + 28'(i * 8), 0);
    cmd = WR; addr = 28'h300; cvalid = 1'b1;
    lows = 0;
    repeat (2) begin
      @(negedge clk);
      if (cready === 1'b0) lows++;
    end
    @(posedge clk); #1;
    cvalid = 1'b0;
    checks++;
    if (lows !== 2) begin errors++; $display("FAIL aq_full_ready low_cycles got=%0d exp=2", lows); end
    for (int i = 8; i < 16; i++) begin
      send_data(d[i], '0);
      model_write(64 + i, d[i], '0);
    end
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      s[i] = s_cready;
    end
    @(posedge clk); #1;
    lows = 0;
    per_ok = 1;
    for (int i = 0; i < 16; i++) begin
      if (s[i] === 1'b0) lows++;
      if (i >= 4 && s[i] !== s[i-4]) per_ok = 0;
    end
    checks++;
    if (lows !== 4) begin errors++; $display("FAIL stall_lows got=%0d exp=4", lows); end
    checks++;
    if (per_ok !== 1'b1) begin errors++; $display("FAIL stall_period pattern=%b exp=period4", s); end
  endtask

  task automatic test_back_to_back();
    rd_t e, o;
    int prev;
    for (int i = 0; i < 16; i++)
      send_cmd(RD, 28'h200 + 28'(i * 8), 1);
    idle(RL + 4);
    checks++;
    if (obs_q.size() !== 16) begin errors++; $display("FAIL b2b_count got=%0d exp=16", obs_q.size()); end
    prev = -1;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if (o.d !== e.d) begin errors++; $display("FAIL b2b_data got=%h exp=%h", o.d, e.d); end
      checks++;
      if (o.c !== e.c) begin errors++; $display("FAIL b2b_latency got=%0d exp=%0d", o.c, e.c); end
      if (prev >= 0) begin
        checks++;
        if (o.c !== prev + 1) begin errors++; $display("FAIL b2b_consecutive got=%0d exp=%0d", o.c, prev + 1); end
      end
      prev = o.c;
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_errors_reset();
    rd_t e, o;
    cmd = 3'd5; addr = '0; cvalid = 1'b1;
    @(negedge clk);
    checks++;
    if (cready !== 1'b1 || err !== 1'b0) begin
      errors++; $display("FAIL err_before ready=%b err=%b exp ready=1 err=0", cready, err);
    end
    @(posedge clk); #1;
    cvalid = 1'b0;
    @(negedge clk);
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL err_rise got=%b exp=1", err); end
    idle(3);
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL err_sticky got=%b exp=1", err); end
    obs_q.delete();
    send_cmd(RD, 28'h0, 0);
    send_cmd(RD, 28'h8, 0);
    rst_n = 1'b0;
    idle(RL + 4);
    checks++;
    if (obs_q.size() !== 0) begin errors++; $display("FAIL rst_inflight valids got=%0d exp=0", obs_q.size()); end
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL rst_err_clear got=%b exp=0", err); end
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);
    send_cmd(WR, 28'h2000, 0);
    @(negedge clk);
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL oor_error got=%b exp=1", err); end
    @(posedge clk); #1;
    send_data({16{32'hDEAD_BEEF}}, '0);
    idle(3);
    send_cmd(RD, 28'h0, 1);
    idle(RL + 4);
    checks++;
    if (obs_q.size() !== 1) begin errors++; $display("FAIL oor_count got=%0d exp=1", obs_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if (o.d !== e.d) begin errors++; $display("FAIL oor_discard got=%h exp=%h", o.d, e.d); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_data_first();
    test_mask();
    test_raw_stall();
    test_backpressure();
    test_back_to_back();
    test_errors_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
